// File: rtl/clk_en_gen_if.sv
// rtl/clk_en_gen_if.sv - configuration write port for clk_en_gen
interface clk_en_gen_if #(
    parameter int ACC_W = 32
) ();
    logic             cfg_valid;
    logic             cfg_ready;
    logic [2:0]       cfg_ch;
    logic [ACC_W-1:0] cfg_inc;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_inc,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_inc,
        output cfg_ready
    );
endinterface

// File: rtl/clk_en_gen.sv
// rtl/clk_en_gen.sv - multi-channel NCO clock-enable generator with lock tracking
module clk_en_gen #(
    parameter int                      NUM_CH      = 2,
    parameter int                      ACC_W       = 32,
    parameter logic [NUM_CH*ACC_W-1:0] INIT_INC    = {NUM_CH{32'h8000_0000}},
    parameter int                      LOCK_CYCLES = 16
) (
    input  logic              refclk,
    input  logic              rst,
    clk_en_gen_if.slave       cfg,
    output logic [NUM_CH-1:0] outclk_en,
    output logic [NUM_CH-1:0] outclk,
    output logic              locked
);
    localparam int             CNT_W    = $clog2(LOCK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        LOCKED = 2'd1,
        RECONF = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_cfg_ready;
    logic               r_locked;
    logic [2:0]         r_cfg_ch;
    logic [ACC_W-1:0]   r_cfg_inc;
    logic [ACC_W-1:0]   r_acc [NUM_CH];
    logic [ACC_W-1:0]   r_inc [NUM_CH];
    logic [NUM_CH-1:0]  r_en;
    logic [NUM_CH-1:0]  r_clk;

    logic [ACC_W:0]     w_sum [NUM_CH];
    logic               w_any_en;
    logic               w_accept;
    logic               w_ch_ok;

    always_comb begin
        w_any_en = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_sum[i] = {1'b0, r_acc[i]} + {1'b0, r_inc[i]};
            if (r_inc[i] != '0) w_any_en = 1'b1;
        end
        w_accept = cfg.cfg_valid & r_cfg_ready;
        w_ch_ok  = int'(cfg.cfg_ch) < NUM_CH;
    end

    // Out-of-range channel writes complete the handshake but never leave SETTLE/LOCKED.
    always_ff @(posedge refclk) begin
        if (!rst) begin
            r_state     <= SETTLE;
            r_cnt       <= '0;
            r_cfg_ready <= 1'b0;
            r_locked    <= 1'b0;
            r_cfg_ch    <= '0;
            r_cfg_inc   <= '0;
        end else begin
            case (r_state)
                RECONF: begin
                    r_state     <= SETTLE;
                    r_cnt       <= '0;
                    r_cfg_ready <= 1'b1;
                    r_locked    <= 1'b0;
                end
                default: begin
                    r_cfg_ready <= 1'b1;
                    if (w_accept && w_ch_ok) begin
                        r_cfg_ch    <= cfg.cfg_ch;
                        r_cfg_inc   <= cfg.cfg_inc;
                        r_state     <= RECONF;
                        r_cfg_ready <= 1'b0;
                        r_locked    <= 1'b0;
                    end else if (r_state == SETTLE) begin
                        if (r_cnt == CNT_LAST) begin
                            if (w_any_en) begin
                                r_state  <= LOCKED;
                                r_locked <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // The carry of each add becomes next cycle's enable pulse; MSB of the sum is the square wave.
    always_ff @(posedge refclk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (!rst) begin
                r_acc[i] <= '0;
                r_inc[i] <= INIT_INC[i*ACC_W +: ACC_W];
                r_en[i]  <= 1'b0;
                r_clk[i] <= 1'b0;
            end else if (r_state == RECONF && int'(r_cfg_ch) == i) begin
                r_acc[i] <= '0;
                r_inc[i] <= r_cfg_inc;
                r_en[i]  <= 1'b0;
                r_clk[i] <= 1'b0;
            end else if (r_inc[i] != '0) begin
                r_acc[i] <= w_sum[i][ACC_W-1:0];
                r_en[i]  <= w_sum[i][ACC_W];
                r_clk[i] <= w_sum[i][ACC_W-1];
            end else begin
                r_en[i]  <= 1'b0;
                r_clk[i] <= 1'b0;
            end
        end
    end

    assign cfg.cfg_ready = r_cfg_ready;
    assign outclk_en     = r_en;
    assign outclk        = r_clk;
    assign locked        = r_locked;
endmodule

// File: tb/tb_clk_en_gen.sv
// tb/tb_clk_en_gen.sv - scoreboard testbench for clk_en_gen
module tb_clk_en_gen;
    localparam int LOCK = 16;

    logic refclk = 1'b0;
    always #5 refclk = ~refclk;

    logic       rst;
    logic [1:0] en_a, clk_a;
    logic       locked_a;
    logic [0:0] en_b, clk_b;
    logic       locked_b;

    clk_en_gen_if #(.ACC_W(32)) cfg_a ();
    clk_en_gen_if #(.ACC_W(8))  cfg_b ();

    clk_en_gen u_dut_a (
        .refclk    (refclk),
        .rst       (rst),
        .cfg       (cfg_a.slave),
        .outclk_en (en_a),
        .outclk    (clk_a),
        .locked    (locked_a)
    );

    clk_en_gen #(.NUM_CH(1), .ACC_W(8), .INIT_INC(8'h51), .LOCK_CYCLES(4)) u_dut_b (
        .refclk    (refclk),
        .rst       (rst),
        .cfg       (cfg_b.slave),
        .outclk_en (en_b),
        .outclk    (clk_b),
        .locked    (locked_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic       locked;
        logic       ready;
        logic [1:0] en;
        logic [1:0] clk;
    } exp_t;
    exp_t sb[$];

    logic [31:0] m_acc [2];
    logic [31:0] m_inc [2];
    int          m_state;
    int          m_cnt;
    logic        m_locked, m_ready;
    logic [1:0]  m_en, m_clk;
    int          m_pch;
    logic [31:0] m_pinc;

    task automatic model_step();
        logic [32:0] s;
        logic        any;
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                m_acc[i] = 32'h0;
                m_inc[i] = 32'h8000_0000;
            end
            m_en = 2'b00; m_clk = 2'b00; m_locked = 1'b0; m_ready = 1'b0;
            m_state = 0; m_cnt = 0;
        end else begin
            any = (m_inc[0] != 0) || (m_inc[1] != 0);
            for (int i = 0; i < 2; i++) begin
                if (m_state == 2 && m_pch == i) begin
                    m_acc[i] = 32'h0; m_inc[i] = m_pinc; m_en[i] = 1'b0; m_clk[i] = 1'b0;
                end else if (m_inc[i] != 0) begin
                    s = {1'b0, m_acc[i]} + {1'b0, m_inc[i]};
                    m_acc[i] = s[31:0]; m_en[i] = s[32]; m_clk[i] = s[31];
                end else begin
                    m_en[i] = 1'b0; m_clk[i] = 1'b0;
                end
            end
            if (m_state == 2) begin
                m_state = 0; m_cnt = 0; m_ready = 1'b1; m_locked = 1'b0;
            end else if (cfg_a.cfg_valid && m_ready && cfg_a.cfg_ch < 3'd2) begin
                m_pch = int'(cfg_a.cfg_ch); m_pinc = cfg_a.cfg_inc;
                m_state = 2; m_ready = 1'b0; m_locked = 1'b0;
            end else begin
                m_ready = 1'b1;
                if (m_state == 0) begin
                    if (m_cnt == LOCK - 1) begin
                        if (any) begin m_state = 1; m_locked = 1'b1; end
                    end else begin
                        m_cnt++;
                    end
                end
            end
        end
        sb.push_back({m_locked, m_ready, m_en, m_clk});
    endtask

    int b_edge = 0, b_cnt = 0, b_last = 0, b_gmin = 1000, b_gmax = 0;

    task automatic tick();
        exp_t e;
        int   g;
        model_step();
        @(posedge refclk);
        @(negedge refclk);
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            check("locked", locked_a, e.locked);
            check("cfg_ready", cfg_a.cfg_ready, e.ready);
            check("outclk_en", en_a, e.en);
            check("outclk", clk_a, e.clk);
        end
        b_edge++;
        if (b_edge <= 2560 && en_b[0]) begin
            b_cnt++;
            if (b_last > 0) begin
                g = b_edge - b_last;
                if (g < b_gmin) b_gmin = g;
                if (g > b_gmax) b_gmax = g;
            end
            b_last = b_edge;
        end
    endtask

    task automatic cfg_write(input logic [2:0] ch, input logic [31:0] inc);
        logic took;
        took = 1'b0;
        cfg_a.cfg_valid = 1'b1; cfg_a.cfg_ch = ch; cfg_a.cfg_inc = inc;
        for (int k = 0; k < 20 && !took; k++) begin
            took = cfg_a.cfg_ready;
            tick();
        end
        cfg_a.cfg_valid = 1'b0;
        if (!took) check("write_timeout", 0, 1);
    endtask

    int   first_pulse, lock_at, breaks, any_out;
    logic prev1, r0, r1, r2;

    initial begin
        rst = 1'b0;
        cfg_a.cfg_valid = 1'b0; cfg_a.cfg_ch = 3'd0; cfg_a.cfg_inc = 32'h0;
        cfg_b.cfg_valid = 1'b0; cfg_b.cfg_ch = 3'd0; cfg_b.cfg_inc = 8'h0;
        @(negedge refclk);
        for (int k = 0; k < 3; k++) tick();
        check("rst_locked", locked_a, 0);
        check("rst_ready", cfg_a.cfg_ready, 0);
        check("rst_en", en_a, 0);
        rst = 1'b1;
        b_edge = 0;

        // reset release: 0x80000000 pulses alternate, lock at cycle 16
        for (int k = 1; k <= LOCK; k++) begin
            tick();
            if (k == 1) check("ready_c1", cfg_a.cfg_ready, 1);
            if (k <= 4) check("alt_en", en_a, (k % 2 == 0) ? 2'b11 : 2'b00);
            if (k == LOCK - 1) check("lock_c15", locked_a, 0);
            if (k == LOCK) check("lock_c16", locked_a, 1);
        end

        // ch0 to quarter rate while locked
        cfg_write(3'd0, 32'h4000_0000);
        check("lock_drop", locked_a, 0);
        first_pulse = 0; lock_at = 0; breaks = 0; prev1 = en_a[1];
        for (int j = 1; j <= 30; j++) begin
            tick();
            if (first_pulse == 0 && en_a[0]) first_pulse = j;
            if (lock_at == 0 && locked_a) lock_at = j;
            if (en_a[1] == prev1) breaks++;
            prev1 = en_a[1];
        end
        check("quarter_first_pulse", first_pulse, 5);
        check("quarter_relock", lock_at, 17);
        check("ch1_unbroken", breaks, 0);

        // all channels disabled, then ch1 re-enabled
        cfg_write(3'd0, 32'h0);
        cfg_write(3'd1, 32'h0);
        any_out = 0;
        for (int j = 0; j < 40; j++) begin
            tick();
            if (en_a != 0 || clk_a != 0 || locked_a) any_out++;
        end
        check("all_off_quiet", any_out, 0);
        cfg_write(3'd1, 32'h8000_0000);
        lock_at = 0;
        for (int j = 1; j <= 30; j++) begin
            tick();
            if (lock_at == 0 && locked_a) lock_at = j;
        end
        check("reenable_lock", lock_at, 17);

        // out-of-range channel: discarded without disturbing lock
        cfg_write(3'd5, 32'h1234_5678);
        check("bad_ch_locked", locked_a, 1);
        check("bad_ch_ready", cfg_a.cfg_ready, 1);
        for (int j = 0; j < 4; j++) tick();
        check("bad_ch_still_locked", locked_a, 1);

        while (b_edge < 2570) tick();
        check("b_pulse_count", b_cnt, 810);
        check("b_gap_min", b_gmin, 3);
        check("b_gap_max", b_gmax, 4);

        // cfg_valid held three cycles: accepted on cycles 0 and 2
        cfg_a.cfg_valid = 1'b1; cfg_a.cfg_ch = 3'd1; cfg_a.cfg_inc = 32'h8000_0000;
        r0 = cfg_a.cfg_ready;
        tick();
        cfg_a.cfg_ch = 3'd0; cfg_a.cfg_inc = 32'h2000_0000;
        r1 = cfg_a.cfg_ready;
        tick();
        r2 = cfg_a.cfg_ready;
        tick();
        cfg_a.cfg_valid = 1'b0;
        check("b2b_ready0", r0, 1);
        check("b2b_ready1", r1, 0);
        check("b2b_ready2", r2, 1);
        check("b2b_reconf_ready", cfg_a.cfg_ready, 0);

        // reset lands on the RECONF cycle; pending write is lost
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        for (int k = 1; k <= LOCK; k++) begin
            tick();
            if (k == 1) check("restore_clk", clk_a, 2'b11);
            if (k == 2) check("restore_en", en_a, 2'b11);
            if (k == LOCK) check("restore_lock", locked_a, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
